// File: rtl/arcade_input_mapper_if.sv
// rtl/arcade_input_mapper_if.sv - player/keyboard inputs and cabinet control outputs
interface arcade_input_mapper_if #(
   parameter int NUM_PLAYERS = 2
);
   logic [10:0]               ps2_key;
   logic [16*NUM_PLAYERS-1:0] joy_in;
   logic [4*NUM_PLAYERS-1:0]  dir_n;
   logic [NUM_PLAYERS-1:0]    fire_n;
   logic [NUM_PLAYERS-1:0]    start_n;
   logic [1:0]                coin_n;
   logic                      service_n;
   logic                      pause_state;

   modport master (
      output ps2_key, joy_in,
      input  dir_n, fire_n, start_n, coin_n, service_n, pause_state
   );

   modport slave (
      input  ps2_key, joy_in,
      output dir_n, fire_n, start_n, coin_n, service_n, pause_state
   );
endinterface

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - merges PS/2 keys and joysticks into active-low cabinet controls
// with SOCD cleaning, fixed-length coin pulses and a pause toggle.
module arcade_input_mapper #(
   parameter int NUM_PLAYERS  = 2,
   parameter int COIN_CYCLES  = 2457600,
   parameter int SOCD_NEUTRAL = 1,
   parameter int KBD_ALL      = 1
) (
   input logic clk_49m,
   input logic reset,
   arcade_input_mapper_if.slave io
);
   localparam int CW = $clog2(COIN_CYCLES + 1);
   localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic key_tgl_q;
   logic key_event;
   logic kb_start1, kb_start2, kb_coin1, kb_coin2, kb_service, kb_pause;
   logic kb_up, kb_down, kb_left, kb_right, kb_fire;

   logic [4*NUM_PLAYERS-1:0] dir_d, dir_q;
   logic [NUM_PLAYERS-1:0]   fire_d, fire_q, start_d, start_q;
   logic                     service_q;
   logic                     coin1_m, pause_m, kb_on, u, d, l, r;
   logic [1:0]               coin_m, coin_prev;
   logic [1:0][CW-1:0]       coin_cnt;
   logic                     pause_prev, pause_q;
   logic                     unused_inputs;

   assign key_event     = key_tgl_q != io.ps2_key[10];
   assign unused_inputs = ^{io.ps2_key[8], io.joy_in};

   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         key_tgl_q  <= 1'b0;
         kb_start1  <= 1'b0;
         kb_start2  <= 1'b0;
         kb_coin1   <= 1'b0;
         kb_coin2   <= 1'b0;
         kb_service <= 1'b0;
         kb_pause   <= 1'b0;
         kb_up      <= 1'b0;
         kb_down    <= 1'b0;
         kb_left    <= 1'b0;
         kb_right   <= 1'b0;
         kb_fire    <= 1'b0;
      end else begin
         key_tgl_q <= io.ps2_key[10];
         if (key_event) begin
            case (io.ps2_key[7:0])
               8'h16:   kb_start1  <= io.ps2_key[9];
               8'h1E:   kb_start2  <= io.ps2_key[9];
               8'h2E:   kb_coin1   <= io.ps2_key[9];
               8'h36:   kb_coin2   <= io.ps2_key[9];
               8'h46:   kb_service <= io.ps2_key[9];
               8'h4D:   kb_pause   <= io.ps2_key[9];
               8'h75:   kb_up      <= io.ps2_key[9];
               8'h72:   kb_down    <= io.ps2_key[9];
               8'h6B:   kb_left    <= io.ps2_key[9];
               8'h74:   kb_right   <= io.ps2_key[9];
               8'h14:   kb_fire    <= io.ps2_key[9];
               default: ;
            endcase
         end
      end
   end

   // Keyboard start keys map to the first two players only; directions/fire follow KBD_ALL.
   always_comb begin
      dir_d   = '1;
      fire_d  = '1;
      start_d = '1;
      coin1_m = kb_coin1;
      pause_m = kb_pause;
      kb_on   = 1'b0;
      u = 1'b0;
      d = 1'b0;
      l = 1'b0;
      r = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         kb_on = (p == 0) || (KBD_ALL != 0);
         u = io.joy_in[16*p+3] | (kb_on & kb_up);
         d = io.joy_in[16*p+2] | (kb_on & kb_down);
         l = io.joy_in[16*p+1] | (kb_on & kb_left);
         r = io.joy_in[16*p+0] | (kb_on & kb_right);
         if (SOCD_NEUTRAL != 0 && u && d) begin
            u = 1'b0;
            d = 1'b0;
         end
         if (SOCD_NEUTRAL != 0 && l && r) begin
            l = 1'b0;
            r = 1'b0;
         end
         dir_d[4*p +: 4] = ~{d, u, r, l};
         fire_d[p]  = ~(io.joy_in[16*p+4] | (kb_on & kb_fire));
         start_d[p] = ~(io.joy_in[16*p+5] | ((p == 0) & kb_start1) | ((p == 1) & kb_start2));
         coin1_m    = coin1_m | io.joy_in[16*p+6];
         pause_m    = pause_m | io.joy_in[16*p+7];
      end
   end

   assign coin_m = {kb_coin2, coin1_m};

   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         dir_q      <= '1;
         fire_q     <= '1;
         start_q    <= '1;
         service_q  <= 1'b1;
         coin_prev  <= '0;
         coin_cnt   <= '0;
         pause_prev <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         fire_q     <= fire_d;
         start_q    <= start_d;
         service_q  <= ~kb_service;
         coin_prev  <= coin_m;
         pause_prev <= pause_m;
         if (pause_m && !pause_prev)
            pause_q <= ~pause_q;
         // A running pulse masks new rises; the counter never reloads mid-pulse.
         for (int s = 0; s < 2; s++) begin
            if (coin_cnt[s] != '0)
               coin_cnt[s] <= coin_cnt[s] - CNT_ONE;
            else if (coin_m[s] && !coin_prev[s])
               coin_cnt[s] <= COIN_LOAD;
         end
      end
   end

   assign io.dir_n       = dir_q;
   assign io.fire_n      = fire_q;
   assign io.start_n     = start_q;
   assign io.service_n   = service_q;
   assign io.pause_state = pause_q;
   assign io.coin_n      = {coin_cnt[1] == '0, coin_cnt[0] == '0};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper
module tb_arcade_input_mapper;
   localparam int NP = 2;
   localparam int CC = 8;

   logic clk_49m = 1'b0;
   logic reset;
   always #5 clk_49m = ~clk_49m;

   arcade_input_mapper_if #(.NUM_PLAYERS(NP)) io ();

   arcade_input_mapper #(
      .NUM_PLAYERS(NP), .COIN_CYCLES(CC), .SOCD_NEUTRAL(1), .KBD_ALL(1)
   ) dut (
      .clk_49m(clk_49m),
      .reset  (reset),
      .io     (io)
   );

   // {dir_n[7:0], fire_n[1:0], start_n[1:0], coin_n[1:0], service_n, pause_state}
   logic [15:0] sb[$];
   int vectors     = 0;
   int miscompares = 0;

   function automatic logic [15:0] obs();
      return {io.dir_n, io.fire_n, io.start_n, io.coin_n, io.service_n, io.pause_state};
   endfunction

   task automatic key(input logic pressed, input logic [7:0] code);
      io.ps2_key = {~io.ps2_key[10], pressed, 1'b0, code};
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) io.joy_in = 32'h000F_000F;
         else begin
            io.joy_in = '0;
            reset = 1'b1;
         end
         sb.push_back(16'hFFFE);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_kbd_dir();
      logic [15:0] exp;
      logic [15:0] want [6] = '{16'hFFFE, 16'hBBFE, 16'hBBFE, 16'hBBFE, 16'hFFFE, 16'hFFFE};
      for (int i = 0; i < 6; i++) begin
         if (i == 0) key(1'b1, 8'h75);
         if (i == 3) key(1'b0, 8'h75);
         sb.push_back(want[i]);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL kbd_dir cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_socd();
      logic [15:0] exp;
      logic [31:0] joy  [4] = '{32'h0000_000C, 32'h0000_0008, 32'h000B_0008, 32'h0000_0000};
      logic [15:0] want [4] = '{16'hFFFE, 16'hFBFE, 16'hBBFE, 16'hFFFE};
      for (int i = 0; i < 4; i++) begin
         io.joy_in = joy[i];
         sb.push_back(want[i]);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL socd cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_coin();
      logic [15:0] exp;
      for (int i = 1; i <= 22; i++) begin
         io.joy_in = (i <= 20 && i != 4) ? 32'h0040_0000 : 32'h0;
         sb.push_back(i <= CC ? 16'hFFFA : 16'hFFFE);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL coin cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_dual_coin();
      logic [15:0] exp;
      for (int i = 1; i <= 13; i++) begin
         if (i == 1) key(1'b1, 8'h36);
         if (i == 12) key(1'b0, 8'h36);
         io.joy_in = (i >= 2 && i <= 11) ? 32'h0000_0040 : 32'h0;
         sb.push_back((i >= 2 && i <= CC + 1) ? 16'hFFF2 : 16'hFFFE);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL dual_coin cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_pause();
      logic [15:0] exp;
      for (int i = 1; i <= 18; i++) begin
         io.joy_in = (i <= 10 || (i >= 14 && i <= 16)) ? 32'h0000_0080 : 32'h0;
         sb.push_back(i <= 13 ? 16'hFFFF : 16'hFFFE);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL pause cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_reset_coin();
      logic [15:0] exp;
      for (int i = 1; i <= 3; i++) begin
         io.joy_in = 32'h0040_0080;
         sb.push_back(16'hFFFB);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_coin pre cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
      io.joy_in = 32'h0040_0000;
      reset = 1'b0;
      sb.push_back(16'hFFFE);
      #1;
      exp = sb.pop_front(); vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL reset_coin async: got %h want %h", obs(), exp);
      end
      sb.push_back(16'hFFFE);
      @(posedge clk_49m); @(negedge clk_49m);
      exp = sb.pop_front(); vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL reset_coin held: got %h want %h", obs(), exp);
      end
      reset = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         io.joy_in = (i <= 10) ? 32'h0040_0000 : 32'h0;
         sb.push_back(i <= CC ? 16'hFFFA : 16'hFFFE);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_coin post cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_scancode();
      logic [15:0] exp;
      logic [15:0] want [6] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFF3E, 16'hFF3E, 16'hFFFE};
      for (int i = 0; i < 6; i++) begin
         if (i == 0) key(1'b1, 8'h1C);
         if (i == 2) key(1'b1, 8'h14);
         if (i == 4) key(1'b0, 8'h14);
         sb.push_back(want[i]);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL scancode cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      logic [15:0] want [6] = '{16'hFFFE, 16'hFFDE, 16'hFFDC, 16'hFFDC, 16'hFFFC, 16'hFFFE};
      for (int i = 0; i < 6; i++) begin
         if (i == 0) key(1'b1, 8'h1E);
         if (i == 1) key(1'b1, 8'h46);
         if (i == 3) key(1'b0, 8'h1E);
         if (i == 4) key(1'b0, 8'h46);
         sb.push_back(want[i]);
         @(posedge clk_49m); @(negedge clk_49m);
         exp = sb.pop_front(); vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs(), exp);
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      io.ps2_key = '0;
      io.joy_in  = '0;
      @(negedge clk_49m);
      test_reset();
      test_kbd_dir();
      test_socd();
      test_coin();
      test_dual_coin();
      test_pause();
      test_reset_coin();
      test_scancode();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
